// File: rtl/sonar_uc.sv
// Sonar control unit: sequences measure / transmit / wait / rotate per servo position,
// with a per-position measurement timeout and bounded retries. Optional pause: SONAR_UC_PAUSA_EN.
module sonar_uc #(
  parameter int TIMEOUT        = 2_000_000,
  parameter int MAX_TENTATIVAS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       medida_pronto,
  input  logic       envio_pronto,
  input  logic       fim_tempo,
`ifdef SONAR_UC_PAUSA_EN
  input  logic       pausa,
`endif
  output logic       medir,
  output logic       transmitir,
  output logic       conta,
  output logic       girar,
  output logic       zera,
  output logic       pronto,
  output logic       erro_medida,
  output logic [3:0] db_estado
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    TENT_MAX = 3'(MAX_TENTATIVAS);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    MEDE           = 4'd2,
    AGUARDA_MEDIDA = 4'd3,
    TRANSMITE      = 4'd4,
    AGUARDA_ENVIO  = 4'd5,
    ESPERA         = 4'd6,
    GIRA           = 4'd7,
    FIM            = 4'd8
`ifdef SONAR_UC_PAUSA_EN
    ,
    PAUSADO        = 4'd9
`endif
  } state_e;

  state_e        r_state;
  state_e        w_next;
  logic [TW-1:0] r_tmo;
  logic [2:0]    r_tent;
  logic          r_erro;
  logic          w_timeout;
  logic          w_esgotou;

  assign w_timeout = (r_tmo == TMO_LAST);
  assign w_esgotou = (r_tent >= TENT_MAX);

  // NOTE: every output and w_next gets a default before the case, so no latch is inferred.
  always_comb begin
    w_next     = r_state;
    medir      = 1'b0;
    transmitir = 1'b0;
    conta      = 1'b0;
    girar      = 1'b0;
    zera       = 1'b0;
    pronto     = 1'b0;
    unique case (r_state)
      INICIAL: if (ligar) w_next = PREPARA;
      PREPARA: begin
        zera   = 1'b1;
        w_next = MEDE;
      end
      MEDE: begin
        medir  = 1'b1;
        w_next = AGUARDA_MEDIDA;
      end
      AGUARDA_MEDIDA: begin
        // A measurement arriving on the timeout cycle still counts.
        if (medida_pronto)  w_next = TRANSMITE;
        else if (w_timeout) w_next = w_esgotou ? ESPERA : MEDE;
      end
      TRANSMITE: begin
        transmitir = 1'b1;
        w_next     = AGUARDA_ENVIO;
      end
      AGUARDA_ENVIO: if (envio_pronto) w_next = ESPERA;
      ESPERA: begin
        conta = 1'b1;
`ifdef SONAR_UC_PAUSA_EN
        if (pausa) begin
          conta  = 1'b0;
          w_next = PAUSADO;
        end else if (fim_tempo) begin
          w_next = GIRA;
        end
`else
        if (fim_tempo) w_next = GIRA;
`endif
      end
      GIRA: begin
        girar  = 1'b1;
        w_next = ligar ? MEDE : FIM;
      end
      FIM: begin
        pronto = 1'b1;
        w_next = INICIAL;
      end
`ifdef SONAR_UC_PAUSA_EN
      PAUSADO: if (!pausa) w_next = ESPERA;
`endif
      default: w_next = INICIAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= INICIAL;
      r_tmo   <= '0;
      r_tent  <= '0;
      r_erro  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        PREPARA: r_tent <= '0;
        MEDE: begin
          r_tmo <= '0;
          if (r_tent != 3'd7) r_tent <= r_tent + 3'd1;
        end
        AGUARDA_MEDIDA: begin
          // Saturate at the last count so the counter never wraps while waiting.
          if (!w_timeout) r_tmo <= r_tmo + 1'b1;
          if (medida_pronto)               r_erro <= 1'b0;
          else if (w_timeout && w_esgotou) r_erro <= 1'b1;
        end
        GIRA: r_tent <= '0;
        default: ;
      endcase
    end
  end

  assign erro_medida = r_erro;
  assign db_estado   = r_state;

endmodule
